// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined N-operand unsigned adder tree with valid/ready
// flow control. One register level per tree stage; every stage can advance
// independently, so an empty stage keeps accepting while downstream stalls.
// The full-width sum of the last stage is sliced to DATA_OUT_WIDTH bits
// (top bits for a scaled result, bottom bits for modulo wrap-around).
module adder_tree_pipe #(
   parameter int NUM_INPUTS     = 4,
   parameter int DATA_IN_WIDTH  = 8,
   parameter int DATA_OUT_WIDTH = 8,
   parameter bit TAKE_MSB       = 1'b1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [NUM_INPUTS*DATA_IN_WIDTH-1:0] data_in,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DATA_OUT_WIDTH-1:0]           data_out
);

   localparam int LEVELS     = $clog2(NUM_INPUTS);
   localparam int FULL_WIDTH = DATA_IN_WIDTH + LEVELS;
   localparam int HALF       = NUM_INPUTS / 2;

   // Partial sums are kept in FULL_WIDTH containers. A stage-k sum only ever
   // occupies its low DATA_IN_WIDTH+k bits (the bits above are always zero),
   // so each pairwise add is carry-exact without per-stage width bookkeeping.
   logic [FULL_WIDTH-1:0] lane_in [0:NUM_INPUTS-1];
   logic [FULL_WIDTH-1:0] sum_p   [1:LEVELS][0:HALF-1];
   logic [LEVELS:1]       vld_p;
   logic [LEVELS:1]       adv;

   // Select the visible slice of the full-width sum.
   function automatic logic [DATA_OUT_WIDTH-1:0] slice_out(input logic [FULL_WIDTH-1:0] s);
      if (TAKE_MSB)
         return s[FULL_WIDTH-1 -: DATA_OUT_WIDTH];
      else
         return s[DATA_OUT_WIDTH-1:0];
   endfunction

   // Unpack operand lanes and zero-extend them to the container width.
   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         lane_in[i] = {{LEVELS{1'b0}}, data_in[i*DATA_IN_WIDTH +: DATA_IN_WIDTH]};
      end
   end

   // Advance chain from the output back to the input: a stage may load when
   // it is empty or when the stage after it is advancing.
   always_comb begin
      logic run;
      adv = '0;
      run = out_ready | ~vld_p[LEVELS];
      adv[LEVELS] = run;
      for (int k = LEVELS - 1; k >= 1; k--) begin
         run    = run | ~vld_p[k];
         adv[k] = run;
      end
   end

   // Stage registers: data loads together with its valid bit; a stage that
   // cannot advance holds both. Reset clears valids and data alike.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
         for (int k = 1; k <= LEVELS; k++) begin
            for (int j = 0; j < HALF; j++) begin
               sum_p[k][j] <= '0;
            end
         end
      end else begin
         // stage 1: pair input lanes
         if (adv[1]) begin
            vld_p[1] <= in_valid;
            for (int j = 0; j < HALF; j++) begin
               sum_p[1][j] <= lane_in[2*j] + lane_in[2*j+1];
            end
         end
         // stages 2..LEVELS: pair the previous stage's sums
         for (int k = 2; k <= LEVELS; k++) begin
            if (adv[k]) begin
               vld_p[k] <= vld_p[k-1];
               for (int j = 0; j < (NUM_INPUTS >> k); j++) begin
                  sum_p[k][j] <= sum_p[k-1][2*j] + sum_p[k-1][2*j+1];
               end
            end
         end
      end
   end

   assign in_ready  = adv[1];
   assign out_valid = vld_p[LEVELS];
   assign data_out  = slice_out(sum_p[LEVELS][0]);

endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb_adder_tree_pipe: directed scenarios plus a randomized handshake run
// scored against a queue of plainly computed sums. Two instances share the
// stimulus: one slicing the MSBs, one the LSBs of the sum.
module tb_adder_tree_pipe;

   localparam int N  = 4;
   localparam int IW = 8;
   localparam int OW = 8;
   localparam int LV = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic [N*IW-1:0] data_in;
   logic          ir_m, ov_m, ir_l, ov_l;
   logic [OW-1:0] do_m, do_l;

   logic          o_ir, o_ov, o_irl, o_ovl;
   logic [OW-1:0] o_dm, o_dl;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   adder_tree_pipe #(.NUM_INPUTS(N), .DATA_IN_WIDTH(IW), .DATA_OUT_WIDTH(OW), .TAKE_MSB(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_m), .data_in(data_in),
      .out_valid(ov_m), .out_ready(out_ready), .data_out(do_m));

   adder_tree_pipe #(.NUM_INPUTS(N), .DATA_IN_WIDTH(IW), .DATA_OUT_WIDTH(OW), .TAKE_MSB(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_l), .data_in(data_in),
      .out_valid(ov_l), .out_ready(out_ready), .data_out(do_l));

   function automatic int ref_sum(input logic [N*IW-1:0] d);
      int s = 0;
      for (int i = 0; i < N; i++) s += int'((d >> (IW*i)) & 32'hFF);
      return s;
   endfunction

   // 10-bit sum, 8-bit output: MSB slice divides by 4, LSB slice wraps at 256.
   function automatic logic [OW-1:0] ref_msb(input int s);
      return OW'(s / 4);
   endfunction

   function automatic logic [OW-1:0] ref_lsb(input int s);
      return OW'(s % 256);
   endfunction

   function automatic logic [N*IW-1:0] pack(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   // One clock cycle: drive inputs, sample outputs at the falling edge, then
   // step to just after the next rising edge.
   task automatic cyc(input logic iv, input logic [N*IW-1:0] d, input logic ordy);
      in_valid  = iv;
      data_in   = d;
      out_ready = ordy;
      @(negedge clk);
      o_ir = ir_m; o_ov = ov_m; o_dm = do_m;
      o_irl = ir_l; o_ovl = ov_l; o_dl = do_l;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1; in_valid = 1'b1; data_in = '1; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b0 || o_ovl !== 1'b0) $display("FAIL reset_out_valid: got %b/%b want 0", o_ov, o_ovl); else passes++;
      checks++; if (o_dm !== 8'd0 || o_dl !== 8'd0) $display("FAIL reset_data_out: got %0d/%0d want 0", o_dm, o_dl); else passes++;
      checks++; if (o_ir !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", o_ir); else passes++;
      bad = 0;
      repeat (3) begin
         cyc(1'b0, '0, 1'b1);
         if (o_ov !== 1'b0 || o_ovl !== 1'b0) bad++;
      end
      checks++; if (bad != 0) $display("FAIL reset_capture: got %0d outputs want 0", bad); else passes++;
   endtask

   task automatic test_max_sum();
      logic [N*IW-1:0] d;
      d = pack(255, 255, 255, 255);
      cyc(1'b1, d, 1'b1);
      checks++; if (o_ir !== 1'b1) $display("FAIL max_accept: got %b want 1", o_ir); else passes++;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b0) $display("FAIL max_early: got %b want 0", o_ov); else passes++;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b1) $display("FAIL max_valid: got %b want 1", o_ov); else passes++;
      checks++; if (o_dm !== 8'hFF) $display("FAIL max_msb: got %0h want ff", o_dm); else passes++;
      checks++; if (o_dl !== 8'hFC) $display("FAIL max_lsb: got %0h want fc", o_dl); else passes++;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b0) $display("FAIL max_single: got %b want 0", o_ov); else passes++;
   endtask

   task automatic test_small();
      cyc(1'b1, pack(1, 2, 3, 4), 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b1 || o_dm !== 8'd2) $display("FAIL small_msb: got v=%b d=%0d want v=1 d=2", o_ov, o_dm); else passes++;
      checks++; if (o_dl !== 8'd10) $display("FAIL small_lsb: got %0d want 10", o_dl); else passes++;
   endtask

   task automatic test_back_to_back();
      int ir_bad = 0;
      for (int c = 0; c < 36; c++) begin
         logic ev;
         if (c < 32) cyc(1'b1, pack(c, c, c, c), 1'b1);
         else        cyc(1'b0, '0, 1'b1);
         if (c < 32 && o_ir !== 1'b1) ir_bad++;
         ev = (c >= 2 && c < 34);
         checks++; if (o_ov !== ev) $display("FAIL b2b_valid c=%0d: got %b want %b", c, o_ov, ev); else passes++;
         if (ev) begin
            checks++; if (o_dm !== 8'(c-2)) $display("FAIL b2b_msb c=%0d: got %0d want %0d", c, o_dm, c-2); else passes++;
            checks++; if (o_dl !== ref_lsb(4*(c-2))) $display("FAIL b2b_lsb c=%0d: got %0d want %0d", c, o_dl, ref_lsb(4*(c-2))); else passes++;
         end
      end
      checks++; if (ir_bad != 0) $display("FAIL b2b_in_ready: got %0d stalls want 0", ir_bad); else passes++;
   endtask

   task automatic test_stall();
      logic [N*IW-1:0] a, b, c;
      a = $urandom; b = $urandom; c = $urandom;
      cyc(1'b1, a, 1'b0);
      checks++; if (o_ir !== 1'b1) $display("FAIL stall_acc1: got %b want 1", o_ir); else passes++;
      cyc(1'b1, b, 1'b0);
      checks++; if (o_ir !== 1'b1) $display("FAIL stall_acc2: got %b want 1", o_ir); else passes++;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, c, 1'b0);
         checks++; if (o_ir !== 1'b0) $display("FAIL stall_full i=%0d: got %b want 0", i, o_ir); else passes++;
         checks++; if (o_ov !== 1'b1 || o_dm !== ref_msb(ref_sum(a))) $display("FAIL stall_hold i=%0d: got v=%b d=%0d want v=1 d=%0d", i, o_ov, o_dm, ref_msb(ref_sum(a))); else passes++;
      end
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ir !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", o_ir); else passes++;
      checks++; if (o_ov !== 1'b1 || o_dm !== ref_msb(ref_sum(a))) $display("FAIL stall_drain1: got v=%b d=%0d want v=1 d=%0d", o_ov, o_dm, ref_msb(ref_sum(a))); else passes++;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b1 || o_dm !== ref_msb(ref_sum(b))) $display("FAIL stall_drain2: got v=%b d=%0d want v=1 d=%0d", o_ov, o_dm, ref_msb(ref_sum(b))); else passes++;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b0) $display("FAIL stall_empty: got %b want 0", o_ov); else passes++;
   endtask

   task automatic test_bubble();
      logic [N*IW-1:0] s1, s2, s3;
      s1 = $urandom; s2 = $urandom; s3 = $urandom;
      cyc(1'b1, s1, 1'b0);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b1, s2, 1'b0);
      checks++; if (o_ir !== 1'b1) $display("FAIL bubble_accept: got %b want 1", o_ir); else passes++;
      cyc(1'b1, s3, 1'b0);
      checks++; if (o_ir !== 1'b0) $display("FAIL bubble_refuse: got %b want 0", o_ir); else passes++;
      cyc(1'b1, s3, 1'b1);
      checks++; if (o_ir !== 1'b1) $display("FAIL bubble_drain_accept: got %b want 1", o_ir); else passes++;
      checks++; if (o_ov !== 1'b1 || o_dm !== ref_msb(ref_sum(s1))) $display("FAIL bubble_out1: got v=%b d=%0d want v=1 d=%0d", o_ov, o_dm, ref_msb(ref_sum(s1))); else passes++;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b1 || o_dm !== ref_msb(ref_sum(s2))) $display("FAIL bubble_out2: got v=%b d=%0d want v=1 d=%0d", o_ov, o_dm, ref_msb(ref_sum(s2))); else passes++;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b1 || o_dl !== ref_lsb(ref_sum(s3))) $display("FAIL bubble_out3: got v=%b d=%0d want v=1 d=%0d", o_ov, o_dl, ref_lsb(ref_sum(s3))); else passes++;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b0) $display("FAIL bubble_empty: got %b want 0", o_ov); else passes++;
   endtask

   task automatic test_reset_midflight();
      logic [N*IW-1:0] a, b, c, d;
      int stale;
      a = $urandom; b = $urandom; c = $urandom; d = pack(10, 20, 30, 40);
      cyc(1'b1, a, 1'b0);
      cyc(1'b1, b, 1'b0);
      rst = 1'b1;
      cyc(1'b1, c, 1'b0);
      rst = 1'b0;
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b0 || o_dm !== 8'd0 || o_dl !== 8'd0) $display("FAIL midrst_clear: got v=%b d=%0d/%0d want v=0 d=0/0", o_ov, o_dm, o_dl); else passes++;
      checks++; if (o_ir !== 1'b1) $display("FAIL midrst_ready: got %b want 1", o_ir); else passes++;
      stale = 0;
      repeat (4) begin
         cyc(1'b0, '0, 1'b1);
         if (o_ov !== 1'b0) stale++;
      end
      checks++; if (stale != 0) $display("FAIL midrst_stale: got %0d outputs want 0", stale); else passes++;
      cyc(1'b1, d, 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      checks++; if (o_ov !== 1'b1 || o_dm !== 8'd25) $display("FAIL midrst_fresh: got v=%b d=%0d want v=1 d=25", o_ov, o_dm); else passes++;
   endtask

   task automatic test_random();
      int q[$];
      int accepted = 0;
      int cycles = 0;
      while ((accepted < 1000 || q.size() > 0) && cycles < 20000) begin
         logic iv, ordy, exp_ir;
         logic [N*IW-1:0] d;
         iv   = (accepted < 1000) && ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 6);
         d    = $urandom;
         exp_ir = (q.size() < LV) || ordy;
         cyc(iv, d, ordy);
         cycles++;
         checks++; if (o_ir !== exp_ir || o_irl !== exp_ir) $display("FAIL rand_in_ready cyc=%0d: got %b/%b want %b", cycles, o_ir, o_irl, exp_ir); else passes++;
         if (o_ov === 1'b1 && ordy) begin
            checks++;
            if (q.size() == 0) $display("FAIL rand_spurious cyc=%0d: got d=%0d want no output", cycles, o_dm);
            else if (o_dm !== ref_msb(q[0]) || o_dl !== ref_lsb(q[0]) || o_ovl !== 1'b1)
               $display("FAIL rand_data cyc=%0d: got %0d/%0d want %0d/%0d", cycles, o_dm, o_dl, ref_msb(q[0]), ref_lsb(q[0]));
            else passes++;
            if (q.size() > 0) void'(q.pop_front());
         end
         if (iv && o_ir === 1'b1) begin
            q.push_back(ref_sum(d));
            accepted++;
         end
      end
      checks++; if (accepted != 1000 || q.size() != 0) $display("FAIL rand_complete: got accepted=%0d pending=%0d want 1000/0", accepted, q.size()); else passes++;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
      test_reset();
      test_max_sum();
      test_small();
      test_back_to_back();
      test_stall();
      test_bubble();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
